// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side drain engine for the async FIFO. It runs entirely in the read
//   clock domain. It pops words from the FIFO head and presents them on a
//   valid/ready stream through a 2-entry skid buffer. It sustains one word
//   per cycle, frames the output into fixed-length bursts, and counts the
//   words it delivers.
// Ports:
//   r_clk, r_rst     read clock, synchronous active-high reset
//   r_en             pop enable (buffered words drain regardless)
//   r_empty, r_data  FIFO empty flag and asynchronous head word
//   r_inc            pop strobe to the FIFO (combinational)
//   m_data/m_valid/m_ready/m_last  output stream with burst framing
//   words_out        delivered-word counter (wraps)
//   busy             buffer or FIFO holds data
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  r_en,
  input  logic                  r_empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_inc,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic                  busy
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  // Beat counter is 8 bits wide so that BURST_LEN=256 still fits (0..255).
  localparam logic [7:0]           LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_entry0;
  logic [DATA_WIDTH-1:0] r_entry1;
  logic [7:0]            r_beat;
  logic [CNT_WIDTH-1:0]  r_words;

  logic w_xfer;
  logic w_pop;

  assign m_valid = (r_state != S_EMPTY);
  assign w_xfer  = m_valid & m_ready;
  // A full buffer can still accept a pop when the head leaves in the same
  // cycle. This makes r_inc depend combinationally on m_ready.
  assign w_pop   = ~r_rst & r_en & ~r_empty & ((r_state != S_TWO) | w_xfer);

  assign r_inc     = w_pop;
  assign m_data    = r_entry0;
  assign m_last    = m_valid & (r_beat == LAST_BEAT);
  assign words_out = r_words;
  assign busy      = (r_state != S_EMPTY) | ~r_empty;

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_state  <= S_EMPTY;
      r_entry0 <= '0;
      r_entry1 <= '0;
      r_beat   <= '0;
      r_words  <= '0;
    end else begin
      if (w_xfer) begin
        r_beat  <= (r_beat == LAST_BEAT) ? 8'd0 : r_beat + 8'd1;
        r_words <= r_words + CNT_ONE;
      end
      unique case (r_state)
        S_EMPTY: begin
          if (w_pop) begin
            r_entry0 <= r_data;
            r_state  <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_pop && w_xfer) begin
            r_entry0 <= r_data;
          end else if (w_pop) begin
            r_entry1 <= r_data;
            r_state  <= S_TWO;
          end else if (w_xfer) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          // When the buffer is full, a pop only happens together with a transfer.
          if (w_xfer) begin
            r_entry0 <= r_entry1;
            if (w_pop) r_entry1 <= r_data;
            else       r_state  <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  logic       r_clk = 1'b0;
  logic       r_rst, r_en, r_empty, r_inc, m_valid, m_ready, m_last, busy;
  logic [7:0] r_data, m_data;
  logic [15:0] words_out;

  int checks = 0;
  int errors = 0;

  // FIFO model: word store with read/write pointers; gap forces empty.
  logic [7:0] mem [0:2047];
  int   rd = 0;
  int   wr = 0;
  logic gap = 1'b0;
  int   mon_pops = 0;
  int   mon_xfers = 0;

  assign r_empty = gap | (rd == wr);
  assign r_data  = mem[rd % 2048];

  always #5 r_clk = ~r_clk;

  always @(posedge r_clk) begin
    if (r_inc) rd <= rd + 1;
    if (r_inc) mon_pops <= mon_pops + 1;
    if (m_valid && m_ready) mon_xfers <= mon_xfers + 1;
  end

  fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(4), .CNT_WIDTH(16)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .r_en(r_en), .r_empty(r_empty),
    .r_data(r_data), .r_inc(r_inc), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .words_out(words_out), .busy(busy)
  );

  task automatic push(input logic [7:0] b);
    mem[wr % 2048] = b;
    wr = wr + 1;
  endtask

  // Inputs change at the negedge; checks happen 1 time unit later.
  task automatic test_reset;
    r_rst = 1'b1; r_en = 1'b1; m_ready = 1'b1; gap = 1'b0;
    push(8'hAA);
    @(negedge r_clk); @(negedge r_clk); #1;
    checks++; if (r_inc !== 1'b0) begin errors++; $display("FAIL rst_inc got %b exp 0", r_inc); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", m_data); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL rst_last got %b exp 0", m_last); end
    checks++; if (words_out !== 16'd0) begin errors++; $display("FAIL rst_words got %0d exp 0", words_out); end
    wr = rd;  // discard the preloaded word
    @(negedge r_clk); r_rst = 1'b0;
    #1;
    checks++; if (r_inc !== 1'b0) begin errors++; $display("FAIL idle_inc got %b exp 0", r_inc); end
    @(negedge r_clk); #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
    checks++; if (words_out !== 16'd0) begin errors++; $display("FAIL idle_words got %0d exp 0", words_out); end
  endtask

  task automatic test_stream;
    @(negedge r_clk);
    m_ready = 1'b1;
    for (int k = 1; k <= 8; k++) push(8'(k));
    #1;
    for (int i = 0; i <= 9; i++) begin
      checks++; if (r_inc !== (i < 8)) begin errors++; $display("FAIL stream_inc[%0d] got %b exp %b", i, r_inc, (i < 8)); end
      if (i >= 1 && i <= 8) begin
        checks++; if (m_valid !== 1'b1 || m_data !== 8'(i)) begin errors++; $display("FAIL stream_data[%0d] got %b/%h exp 1/%h", i, m_valid, m_data, 8'(i)); end
        checks++; if (m_last !== (i % 4 == 0)) begin errors++; $display("FAIL stream_last[%0d] got %b exp %b", i, m_last, (i % 4 == 0)); end
      end
      if (i == 9) begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid got %b exp 0", m_valid); end
        checks++; if (words_out !== 16'd8) begin errors++; $display("FAIL stream_words got %0d exp 8", words_out); end
      end
      @(negedge r_clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int p0;
    @(negedge r_clk);
    m_ready = 1'b0;
    p0 = mon_pops;
    for (int k = 0; k < 6; k++) push(8'h10 + 8'(k));
    for (int c = 0; c < 5; c++) begin
      @(negedge r_clk); #1;
      checks++; if (m_valid !== 1'b1 || m_data !== 8'h10) begin errors++; $display("FAIL bp_hold[%0d] got %b/%h exp 1/10", c, m_valid, m_data); end
    end
    checks++; if (mon_pops - p0 != 2) begin errors++; $display("FAIL bp_pops got %0d exp 2", mon_pops - p0); end
    @(negedge r_clk); m_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      #1;
      checks++; if (m_valid !== 1'b1 || m_data !== 8'h10 + 8'(j)) begin errors++; $display("FAIL bp_data[%0d] got %b/%h exp 1/%h", j, m_valid, m_data, 8'h10 + 8'(j)); end
      checks++; if (m_last !== (j == 3)) begin errors++; $display("FAIL bp_last[%0d] got %b exp %b", j, m_last, (j == 3)); end
      @(negedge r_clk);
    end
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %b exp 0", m_valid); end
    checks++; if (words_out !== 16'd14) begin errors++; $display("FAIL bp_words got %0d exp 14", words_out); end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int d, cyc, p0, x0, occ;
    d = 0; cyc = 0;
    p0 = mon_pops; x0 = mon_xfers;
    for (int k = 0; k < 1000; k++) begin
      b = 8'($urandom);
      push(b);
      exp_q.push_back(b);
    end
    while (d < 1000 && cyc < 20000) begin
      @(negedge r_clk);
      gap = ($urandom_range(0, 3) == 0);
      m_ready = $urandom_range(0, 1) == 1;
      #1;
      occ = (mon_pops - p0) - (mon_xfers - x0);
      checks++; if (occ > 2 || m_valid !== (occ != 0)) begin errors++; $display("FAIL rnd_occ got valid %b occ %0d exp occ<=2", m_valid, occ); end
      if (m_valid && m_ready) begin
        checks++; if (m_data !== exp_q[0]) begin errors++; $display("FAIL rnd_data[%0d] got %h exp %h", d, m_data, exp_q[0]); end
        checks++; if (m_last !== ((14 + d) % 4 == 3)) begin errors++; $display("FAIL rnd_last[%0d] got %b exp %b", d, m_last, ((14 + d) % 4 == 3)); end
        void'(exp_q.pop_front());
        d++;
      end
      cyc++;
    end
    checks++; if (d != 1000) begin errors++; $display("FAIL rnd_timeout got %0d words exp 1000", d); end
    @(negedge r_clk); gap = 1'b0; m_ready = 1'b1;
    @(negedge r_clk); #1;
    checks++; if (words_out !== 16'd1014) begin errors++; $display("FAIL rnd_words got %0d exp 1014", words_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_busy got %b exp 0", busy); end
  endtask

  task automatic test_enable;
    @(negedge r_clk);
    m_ready = 1'b0; r_en = 1'b1;
    push(8'h30); push(8'h31); push(8'h32);
    @(negedge r_clk); @(negedge r_clk);
    r_en = 1'b0; m_ready = 1'b1;
    #1;
    checks++; if (r_inc !== 1'b0) begin errors++; $display("FAIL en_inc0 got %b exp 0", r_inc); end
    checks++; if (m_data !== 8'h30 || m_last !== 1'b0) begin errors++; $display("FAIL en_d0 got %h/%b exp 30/0", m_data, m_last); end
    @(negedge r_clk); #1;
    checks++; if (r_inc !== 1'b0) begin errors++; $display("FAIL en_inc1 got %b exp 0", r_inc); end
    checks++; if (m_data !== 8'h31 || m_last !== 1'b1) begin errors++; $display("FAIL en_d1 got %h/%b exp 31/1", m_data, m_last); end
    @(negedge r_clk); #1;
    checks++; if (m_valid !== 1'b0 || busy !== 1'b1 || r_inc !== 1'b0) begin errors++; $display("FAIL en_drained got v%b b%b i%b exp v0 b1 i0", m_valid, busy, r_inc); end
    r_en = 1'b1;
    @(negedge r_clk); #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h32) begin errors++; $display("FAIL en_resume got %b/%h exp 1/32", m_valid, m_data); end
    @(negedge r_clk); #1;
    checks++; if (words_out !== 16'd1017 || m_valid !== 1'b0) begin errors++; $display("FAIL en_words got %0d/%b exp 1017/0", words_out, m_valid); end
  endtask

  task automatic test_reset_midburst;
    @(negedge r_clk); r_rst = 1'b1; m_ready = 1'b1;
    @(negedge r_clk); r_rst = 1'b0;
    push(8'h40); push(8'h41);
    @(negedge r_clk); @(negedge r_clk); @(negedge r_clk);
    m_ready = 1'b0;
    push(8'h50); push(8'h51); push(8'h52);
    @(negedge r_clk); @(negedge r_clk);
    r_rst = 1'b1; m_ready = 1'b1;
    #1;
    checks++; if (r_inc !== 1'b0) begin errors++; $display("FAIL mrst_inc got %b exp 0", r_inc); end
    @(negedge r_clk); r_rst = 1'b0;
    for (int k = 3; k <= 6; k++) push(8'h50 + 8'(k));
    #1;
    checks++; if (m_valid !== 1'b0 || m_data !== 8'h00 || words_out !== 16'd0) begin errors++; $display("FAIL mrst_clear got %b/%h/%0d exp 0/00/0", m_valid, m_data, words_out); end
    for (int j = 0; j < 5; j++) begin
      @(negedge r_clk); #1;
      checks++; if (m_valid !== 1'b1 || m_data !== 8'h52 + 8'(j)) begin errors++; $display("FAIL mrst_data[%0d] got %b/%h exp 1/%h", j, m_valid, m_data, 8'h52 + 8'(j)); end
      checks++; if (m_last !== (j == 3)) begin errors++; $display("FAIL mrst_last[%0d] got %b exp %b", j, m_last, (j == 3)); end
    end
    @(negedge r_clk); #1;
    checks++; if (words_out !== 16'd5) begin errors++; $display("FAIL mrst_words got %0d exp 5", words_out); end
  endtask

  initial begin
    r_rst = 1'b1; r_en = 1'b0; m_ready = 1'b0;
    test_reset;
    test_stream;
    test_backpressure;
    test_random;
    test_enable;
    test_reset_midburst;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
